parity_frame_sched: RTL and testbench

Round-robin scheduler that shares one serial even-ones detector (the Mealy parity FSM: one input bit per clock, output high when the count of ones is even) among N_REQ parallel requesters. It accepts one WIDTH-bit word at a time and clears the detector. It then shifts the word into the detector LSB-first, samples the Mealy output on the last bit, and returns an even/odd verdict tagged with the requester ID. It sits between parallel producers and the serial detector, which stays external.

---
 rtl/parity_frame_sched_if.sv | 35 +++
 rtl/parity_frame_sched.sv | 139 +++++++++++++
 tb/tb_parity_frame_sched.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : parity_frame_sched_if
// Brief    : Requester, detector and verdict signals of the parity scheduler.
// Revision : 1.0
// ============================================================================
interface parity_frame_sched_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   det_w;
    logic                   det_clr;
    logic                   det_z;
    logic                   res_valid;
    logic                   res_even;
    logic [IDW-1:0]         res_id;
    logic                   res_ready;
    logic                   busy;

    // Producers, detector and verdict consumer taken together.
    modport master (
        output req_valid, req_data, det_z, res_ready,
        input  req_ready, det_w, det_clr, res_valid, res_even, res_id, busy
    );

    modport slave (
        input  req_valid, req_data, det_z, res_ready,
        output req_ready, det_w, det_clr, res_valid, res_even, res_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/parity_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : parity_frame_sched
// Brief    : Round-robin sharing of one external serial even-ones detector.
// Revision : 1.0
// ============================================================================
module parity_frame_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  wire logic            pos,
    input  wire logic            rst,
    parity_frame_sched_if.slave  bus
);
    localparam int                c_CNTW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNTW-1:0] c_LAST      = c_CNTW'(WIDTH - 1);
    localparam logic [IDW-1:0]    c_GRANT_RST = IDW'(N_REQ - 1);
    localparam logic [IDW:0]      c_NREQ      = (IDW + 1)'(N_REQ);
    localparam logic [N_REQ-1:0]  c_ONE       = {{(N_REQ - 1){1'b0}}, 1'b1};

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_CLEAR  = 2'd1;
    localparam logic [1:0] c_SHIFT  = 2'd2;
    localparam logic [1:0] c_RESULT = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [IDW-1:0]    r_last_grant;
    logic [WIDTH-1:0]  r_shreg;
    logic [c_CNTW-1:0] r_cnt;
    logic              r_res_even;
    logic [IDW-1:0]    r_res_id;

    logic              w_grant_vld;
    logic [IDW-1:0]    w_grant_idx;
    logic [IDW:0]      w_sum;
    logic [WIDTH-1:0]  w_word;
    logic              w_hs;
    logic              w_det_clr;
    logic              w_det_w;
    logic [N_REQ-1:0]  w_req_ready;

    // Rotating priority search; walking k downward leaves the nearest hit.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_sum = {1'b0, r_last_grant} + (IDW + 1)'(k);
            if (w_sum >= c_NREQ) begin
                w_sum = w_sum - c_NREQ;
            end
            if (bus.req_valid[w_sum[IDW-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_sum[IDW-1:0];
            end
        end
    end

    assign w_word = bus.req_data[w_grant_idx*WIDTH +: WIDTH];

    always_ff @(posedge pos) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_det_clr   = ~rst;
        w_det_w     = 1'b0;
        w_req_ready = '0;
        w_hs        = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_grant_vld && rst) begin
                    w_req_ready = c_ONE << w_grant_idx;
                    w_hs        = 1'b1;
                    w_state_nxt = c_CLEAR;
                end
            end
            c_CLEAR: begin
                w_det_clr   = 1'b1;
                w_state_nxt = c_SHIFT;
            end
            c_SHIFT: begin
                w_det_w = r_shreg[0] & rst;
                if (r_cnt == c_LAST) begin
                    w_state_nxt = c_RESULT;
                end
            end
            c_RESULT: begin
                if (bus.res_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // The Mealy output on the last shifted bit is the whole-word verdict.
    always_ff @(posedge pos) begin
        if (!rst) begin
            r_last_grant <= c_GRANT_RST;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_res_even   <= 1'b0;
            r_res_id     <= '0;
        end else begin
            if (w_hs) begin
                r_shreg      <= w_word;
                r_res_id     <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end else if (r_state == c_SHIFT) begin
                r_shreg <= r_shreg >> 1;
            end
            if (r_state == c_CLEAR) begin
                r_cnt <= '0;
            end else if (r_state == c_SHIFT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == c_SHIFT) && (r_cnt == c_LAST)) begin
                r_res_even <= bus.det_z;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.det_w     = w_det_w;
    assign bus.det_clr   = w_det_clr;
    assign bus.res_valid = (r_state == c_RESULT);
    assign bus.res_even  = r_res_even;
    assign bus.res_id    = r_res_id;
    assign bus.busy      = (r_state != c_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_parity_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_frame_sched
// Brief    : Scoreboard bench for parity_frame_sched with a detector model.
// Revision : 1.0
// ============================================================================
module tb_parity_frame_sched;
    logic pos = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [2:0] sb_q[$];
    logic       exp_even_tab [4];
    logic       det_odd;

    parity_frame_sched_if #(.N_REQ(4), .WIDTH(8)) bus();

    parity_frame_sched #(.N_REQ(4), .WIDTH(8)) dut (
        .pos (pos),
        .rst (rst),
        .bus (bus)
    );

    always #5 pos = ~pos;
    always @(posedge pos) cyc <= cyc + 1;

    // External Mealy even-ones detector.
    always @(posedge pos) det_odd <= bus.det_clr ? 1'b0 : (det_odd ^ bus.det_w);
    assign bus.det_z = ~(det_odd ^ bus.det_w);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge pos) begin
        logic [2:0] e;
        if (rst === 1'b1 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_verdict: got id=%0d even=%0d expected none", bus.res_id, bus.res_even);
            end else begin
                e = sb_q.pop_front();
                check("res_id", 32'(bus.res_id), 32'(e[2:1]));
                check("res_even", 32'(bus.res_even), 32'(e[0]));
            end
        end
    end

    task automatic send_word(input int id, input logic [7:0] word, input logic exp_even);
        int n;
        logic [7:0] seq;
        @(posedge pos); #1;
        bus.req_valid[id] = 1'b1;
        bus.req_data[id*8 +: 8] = word;
        n = 0;
        @(negedge pos);
        while (bus.req_ready[id] !== 1'b1 && n < 50) begin
            @(negedge pos);
            n++;
        end
        check("grant_timeout", 32'(n >= 50), 32'd0);
        if (n < 50) begin
            check("ready_onehot", 32'(bus.req_ready), 32'(4'b1 << id));
            sb_q.push_back({id[1:0], exp_even});
            @(posedge pos); #1;
            bus.req_valid[id] = 1'b0;
            @(negedge pos);
            check("clear_det_clr", 32'(bus.det_clr), 32'd1);
            check("clear_det_w", 32'(bus.det_w), 32'd0);
            for (int i = 0; i < 8; i++) begin
                @(negedge pos);
                seq[i] = bus.det_w;
                if (i == 0) check("shift_det_clr", 32'(bus.det_clr), 32'd0);
            end
            check("det_w_seq", 32'(seq), 32'(word));
            @(negedge pos);
            check("res_valid_latency", 32'(bus.res_valid), 32'd1);
        end
    endtask

    task automatic run_grants(input int n, input logic [15:0] order);
        int wait_n;
        int last_cyc;
        logic [1:0] g;
        last_cyc = 0;
        for (int k = 0; k < n; k++) begin
            g = order[2*k +: 2];
            wait_n = 0;
            @(negedge pos);
            while (bus.req_ready == 4'b0 && wait_n < 100) begin
                @(negedge pos);
                wait_n++;
            end
            if (wait_n >= 100) begin
                check("grant_wait", 32'(wait_n), 32'd0);
                return;
            end
            check("ready_no_x", 32'($isunknown(bus.req_ready)), 32'd0);
            check("grant_order", 32'(bus.req_ready), 32'(4'b1 << g));
            sb_q.push_back({g, exp_even_tab[g]});
            if (k > 0) check("frame_spacing", 32'(cyc - last_cyc), 32'd11);
            last_cyc = cyc;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.busy) && n < 200) begin
            @(negedge pos);
            n++;
        end
        check("drain_timeout", 32'(n >= 200), 32'd0);
    endtask

    initial begin
        int n;
        rst           = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_data  = '0;
        bus.res_ready = 1'b1;

        // Reset behaviour.
        for (int i = 0; i < 3; i++) begin
            @(negedge pos);
            check("rst_det_clr", 32'(bus.det_clr), 32'd1);
            check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge pos); #1;
        bus.req_valid = 4'h0;
        @(negedge pos);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_det_w", 32'(bus.det_w), 32'd0);
        check("rst_res_id", 32'(bus.res_id), 32'd0);
        check("rst_res_even", 32'(bus.res_even), 32'd0);
        @(posedge pos); #1;
        rst = 1'b1;

        // Single words.
        send_word(0, 8'h00, 1'b1);
        send_word(1, 8'h01, 1'b0);
        send_word(2, 8'hFF, 1'b1);
        send_word(0, 8'hA5, 1'b1);
        send_word(3, 8'h07, 1'b0);
        drain();

        // All requesters valid: strict rotation.
        bus.req_data = {8'h0E, 8'h0F, 8'h01, 8'h03};
        exp_even_tab[0] = 1'b1;
        exp_even_tab[1] = 1'b0;
        exp_even_tab[2] = 1'b1;
        exp_even_tab[3] = 1'b0;
        @(posedge pos); #1;
        bus.req_valid = 4'hF;
        run_grants(8, 16'hE4E4);
        @(posedge pos); #1;
        bus.req_valid = 4'h0;
        drain();

        // Verdict held while the consumer stalls.
        bus.res_ready = 1'b0;
        bus.req_data[2*8 +: 8] = 8'h33;
        exp_even_tab[2] = 1'b1;
        @(posedge pos); #1;
        bus.req_valid[2] = 1'b1;
        run_grants(1, 16'h0002);
        @(posedge pos); #1;
        bus.req_valid[2] = 1'b0;
        bus.req_data[0 +: 8] = 8'h80;
        exp_even_tab[0] = 1'b0;
        bus.req_valid[0] = 1'b1;
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 30) begin
            @(negedge pos);
            n++;
        end
        check("hold_wait", 32'(n >= 30), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge pos);
            check("hold_res_valid", 32'(bus.res_valid), 32'd1);
            check("hold_res_even", 32'(bus.res_even), 32'd1);
            check("hold_res_id", 32'(bus.res_id), 32'd2);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge pos); #1;
        bus.res_ready = 1'b1;
        run_grants(1, 16'h0000);
        @(posedge pos); #1;
        bus.req_valid = 4'h0;
        drain();

        // Reset in the fourth SHIFT cycle drops the frame.
        bus.req_data[1*8 +: 8] = 8'hFF;
        @(posedge pos); #1;
        bus.req_valid[1] = 1'b1;
        n = 0;
        @(negedge pos);
        while (bus.req_ready[1] !== 1'b1 && n < 50) begin
            @(negedge pos);
            n++;
        end
        check("abort_grant", 32'(n >= 50), 32'd0);
        @(posedge pos); #1;
        bus.req_valid[1] = 1'b0;
        bus.req_valid[3] = 1'b1;
        repeat (4) @(posedge pos);
        #1;
        rst = 1'b0;
        @(negedge pos);
        check("abort_det_clr", 32'(bus.det_clr), 32'd1);
        check("abort_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge pos);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_res_valid", 32'(bus.res_valid), 32'd0);
        check("abort_det_clr2", 32'(bus.det_clr), 32'd1);
        @(posedge pos); #1;
        bus.req_valid = 4'h0;
        rst = 1'b1;
        send_word(1, 8'h0B, 1'b0);
        drain();

        // Requester 2 withdraws before it is granted.
        bus.req_data = {8'h70, 8'h00, 8'h11, 8'h3C};
        exp_even_tab[0] = 1'b1;
        exp_even_tab[1] = 1'b1;
        exp_even_tab[3] = 1'b0;
        @(posedge pos); #1;
        bus.req_valid[0] = 1'b1;
        run_grants(1, 16'h0000);
        @(posedge pos); #1;
        bus.req_valid = 4'b1110;
        @(posedge pos); #1;
        @(posedge pos); #1;
        bus.req_valid[2] = 1'b0;
        run_grants(4, 16'h00DD);
        @(posedge pos); #1;
        bus.req_valid = 4'h0;
        drain();

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
